branch_ctrl: RTL
================

Name: branch_ctrl

Overview:
- Branch resolution and recovery controller for the 5-stage pipeline.
- Provides fetch-stage taken/not-taken predictions from a 2-bit-counter branch history table (BHT).
- Compares EX-stage branch outcome (from the existing takeBranch evaluator) against the prediction carried down the pipe.
- On mismatch, issues a registered PC redirect and holds pipeline flush for a fixed number of cycles.

Parameters:
- BITWIDTH, 32, datapath / PC width.
- IDX_BITS, 4, BHT index width (2^IDX_BITS entries).
- FLUSH_CYCLES, 2, cycles flush is held after a mispredict (min 1, max 7).

Ports:
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- if_pc  in  BITWIDTH  fetch PC for prediction lookup
- pred_taken  out  1  combinational prediction = MSB of BHT[if_pc[IDX_BITS+1:2]]
- ex_valid  in  1  EX stage holds a live instruction
- ex_opcode  in  4  EX opcode; branch = 4'b0010
- ex_pc  in  BITWIDTH  PC of EX instruction
- ex_target  in  BITWIDTH  computed branch target
- ex_pred_taken  in  1  prediction made at fetch, piped to EX
- ex_taken  in  1  resolved outcome from takeBranch
- redirect_valid  out  1  one-cycle pulse: load redirect_pc into PC
- redirect_pc  out  BITWIDTH  corrected fetch address
- flush  out  1  squash IF/ID/EX younger instructions
- stall_fetch  out  1  equals flush; fetch holds PC while high
- stat_branches  out  32  resolved-branch count (feature only)
- stat_mispredicts  out  32  mispredict count (feature only)

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE; redirect_valid=0; redirect_pc=0; flush=0; stall_fetch=0.
  - Every BHT entry = 2'b01 (weakly not taken); stats=0.
  - Reset mid-flush aborts the flush immediately.
- resolve = ex_valid & (ex_opcode==4'b0010) & (state==IDLE). EX inputs are ignored in FLUSH; those instructions are being squashed.
- mispredict = resolve & (ex_taken != ex_pred_taken).
- Redirect, latency 1 cycle:
  - On the edge after mispredict: redirect_valid=1 for exactly 1 cycle.
  - redirect_pc = ex_taken ? ex_target : ex_pc + 4, truncated to BITWIDTH (wraps at 2^BITWIDTH).
- FSM:
  - IDLE→FLUSH on mispredict; flush count loads FLUSH_CYCLES-1.
  - FLUSH: flush=stall_fetch=1; count decrements each cycle; →IDLE when count==0.
  - flush is high for exactly FLUSH_CYCLES cycles, starting the same cycle as redirect_valid.
  - A correct prediction stays in IDLE with no outputs asserted.
- BHT update on every resolve (correct or not), at index ex_pc[IDX_BITS+1:2]:
  - ex_taken=1: counter +1, saturating at 2'b11.
  - ex_taken=0: counter -1, saturating at 2'b00.
- BHT indexing: PC bits [1:0] ignored; aliasing of PCs with equal index is permitted.
- Same-cycle lookup and update to the same index: pred_taken reflects the old counter value (no bypass); the update is visible next cycle.
- Unconditional func codes (BT 4'b0000, BF 4'b0011) are treated identically to conditional branches.
- Non-branch opcodes never update the BHT and never redirect.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - stat_branches increments on each resolve.
  - stat_mispredicts increments on each mispredict.
  - Both saturate at 32'hFFFFFFFF; both reset to 0.
- Undefined: both ports are still present and tied to 0; no counter flops are synthesised.

Decomposition:
- Shared package / include: opcode constant BRANCH_OP=4'b0010, FSM state encodings IDLE=1'b0 / FLUSH=1'b1, BHT reset value 2'b01, PC increment constant 4.
- One sub-module: branch_bht, which holds the 2^IDX_BITS x 2-bit saturating-counter array.
  - Interface: async read port (lookup index); synchronous update port (index, taken, enable); async reset.
- FSM, redirect logic and stats stay in branch_ctrl.

Test Plan:
- After reset, if_pc=0x10 → pred_taken=0; ex_opcode=4'b1100 (ADD), ex_valid=1, ex_taken=1 → no redirect, no flush, BHT[4] remains 01.
- Branch ex_pc=0x10, ex_pred_taken=0, ex_taken=1, ex_target=0x40 → next cycle redirect_valid=1, redirect_pc=0x40, flush high 2 cycles; then if_pc=0x10 gives pred_taken=1 (counter 10).
- Predicted-taken branch ex_pc=0x20 resolves not taken → redirect_pc=0x24. Repeat with ex_pc=0xFFFFFFFC → redirect_pc=0x00000000 (wrap).
- Five consecutive taken resolves at ex_pc=0x8 → counter saturates at 11; one not-taken resolve → counter 10, pred_taken still 1.
- Mispredict, then a second mispredicting branch presented during FLUSH → ignored: no second redirect, no BHT change. Separately: reset_n low during FLUSH → flush drops asynchronously, BHT back to 01.
- With BRANCH_STATS_EN: 3 branches, 1 mispredict → stat_branches=3, stat_mispredicts=1. Without the macro: both ports read 0.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared constants, FSM state type and the saturating-counter helper for the
// branch resolution controller.
package branch_ctrl_pkg;

  localparam logic [3:0]  BRANCH_OP = 4'b0010;
  localparam logic [1:0]  BHT_RESET = 2'b01;
  localparam int unsigned PC_INC    = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Two-bit counter stepped toward the resolved outcome, pinned at 00 and 11.
  function automatic logic [1:0] satUpdate(input logic [1:0] ctr, input logic taken);
    logic [1:0] nextCtr;
    nextCtr = ctr;
    if (taken && ctr != 2'b11) begin
      nextCtr = ctr + 2'b01;
    end else if (!taken && ctr != 2'b00) begin
      nextCtr = ctr - 2'b01;
    end
    return nextCtr;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: 2^IDX_BITS two-bit saturating counters with an
// asynchronous lookup port and a synchronous update port.
module branch_bht
  import branch_ctrl_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic [IDX_BITS-1:0] rdIdx_i,
  output logic [1:0]          rdCtr_o,
  input  logic                updEn_i,
  input  logic [IDX_BITS-1:0] updIdx_i,
  input  logic                updTaken_i
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0] bht_q [ENTRIES];

  // The read is not bypassed: a same-cycle update becomes visible next cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i] <= BHT_RESET;
      end
    end else if (updEn_i) begin
      bht_q[updIdx_i] <= satUpdate(bht_q[updIdx_i], updTaken_i);
    end
  end

  assign rdCtr_o = bht_q[rdIdx_i];

endmodule

// File: rtl/branch_ctrl.sv
// Branch prediction, EX-stage resolution and mispredict recovery (redirect + flush).
// Define BRANCH_STATS_EN to build the resolved-branch / mispredict counters.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int BITWIDTH     = 32,
  parameter int IDX_BITS     = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [BITWIDTH-1:0] if_pc,
  output logic                pred_taken,
  input  logic                ex_valid,
  input  logic [3:0]          ex_opcode,
  input  logic [BITWIDTH-1:0] ex_pc,
  input  logic [BITWIDTH-1:0] ex_target,
  input  logic                ex_pred_taken,
  input  logic                ex_taken,
  output logic                redirect_valid,
  output logic [BITWIDTH-1:0] redirect_pc,
  output logic                flush,
  output logic                stall_fetch,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts
);

  localparam logic [2:0] FLUSH_CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_e              state_q, state_d;
  logic [2:0]          flushCnt_q, flushCnt_d;
  logic                redirValid_q;
  logic [BITWIDTH-1:0] redirPc_q, redirPc_d;
  logic [1:0]          lookupCtr;
  logic                resolve;
  logic                mispredict;
  logic                unusedBits;

  // Branches arriving while flushing are younger squashed instructions.
  assign resolve    = ex_valid && (ex_opcode == BRANCH_OP) && (state_q == IDLE);
  assign mispredict = resolve && (ex_taken != ex_pred_taken);

  branch_bht #(
    .IDX_BITS (IDX_BITS)
  ) u_bht (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .rdIdx_i    (if_pc[IDX_BITS+1:2]),
    .rdCtr_o    (lookupCtr),
    .updEn_i    (resolve),
    .updIdx_i   (ex_pc[IDX_BITS+1:2]),
    .updTaken_i (ex_taken)
  );

  assign pred_taken = lookupCtr[1];
  assign unusedBits = ^{if_pc[BITWIDTH-1:IDX_BITS+2], if_pc[1:0], lookupCtr[0]};

  always_comb begin
    state_d     = state_q;
    flushCnt_d  = flushCnt_q;
    redirPc_d   = redirPc_q;
    flush       = 1'b0;
    stall_fetch = 1'b0;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d    = FLUSH;
          flushCnt_d = FLUSH_CNT_INIT;
          redirPc_d  = ex_taken ? ex_target : ex_pc + BITWIDTH'(PC_INC);
        end
      end
      FLUSH: begin
        flush       = 1'b1;
        stall_fetch = 1'b1;
        if (flushCnt_q == 3'd0) begin
          state_d = IDLE;
        end else begin
          flushCnt_d = flushCnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      flushCnt_q   <= 3'd0;
      redirValid_q <= 1'b0;
      redirPc_q    <= '0;
    end else begin
      state_q      <= state_d;
      flushCnt_q   <= flushCnt_d;
      redirValid_q <= mispredict;
      redirPc_q    <= redirPc_d;
    end
  end

  assign redirect_valid = redirValid_q;
  assign redirect_pc    = redirPc_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] statBr_q, statBr_d;
  logic [31:0] statMis_q, statMis_d;

  always_comb begin
    statBr_d  = statBr_q;
    statMis_d = statMis_q;
    if (resolve && statBr_q != 32'hFFFF_FFFF) begin
      statBr_d = statBr_q + 32'd1;
    end
    if (mispredict && statMis_q != 32'hFFFF_FFFF) begin
      statMis_d = statMis_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      statBr_q  <= 32'd0;
      statMis_q <= 32'd0;
    end else begin
      statBr_q  <= statBr_d;
      statMis_q <= statMis_d;
    end
  end

  assign stat_branches    = statBr_q;
  assign stat_mispredicts = statMis_q;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule
